c17v2_bist_array: RTL

- Parametrised multi-lane array of the C17V2 two-output benchmark function, with registered outputs and an on-chip BIST controller.
- The LFSR pattern generator drives all lanes; a MISR compacts the lane outputs into a signature that is compared against a golden value.
- Per-lane stuck-at fault injection supports reliability and fault-coverage experiments.
- Sits beside the combinational benchmark netlists as the first self-testing, clocked benchmark target.

---
 rtl/c17_pkg.sv | 32 +++
 rtl/c17v2_lane.sv | 34 +++
 rtl/c17v2_bist_array.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/c17_pkg.sv
// Shared types and constants for the C17V2 BIST array: FSM states,
// default LFSR/MISR constants and the lane-output fold used by the MISR.
package c17_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        RUN,
        DRAIN,
        DONE
    } bist_state_e;

    localparam logic [23:0] C17_LFSR_TAPS = 24'hE10000;
    localparam logic [23:0] C17_LFSR_SEED = 24'hACE1A5;
    localparam logic [15:0] C17_MISR_POLY = 16'h1021;

    // XOR n output bits into a w-bit word, bit j landing on j mod w.
    // Covers up to 8 lanes (16 bits) and signatures up to 32 bits wide.
    function automatic logic [31:0] misr_fold(input logic [15:0] v,
                                              input int unsigned n,
                                              input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned j = 0; j < 16; j++) begin
            if (j < n) begin
                r[5'(j % w)] = r[5'(j % w)] ^ v[4'(j)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/c17v2_lane.sv
// One C17V2 lane: the two-output NAND benchmark function followed by a
// stuck-at override on either output.
module c17v2_lane (
    input  logic [4:0] g_in_i,     // {G5,G4,G3,G2,G1}
    input  logic       force_en_i,
    input  logic       force_bit_i, // 0 = G6, 1 = G7
    input  logic       force_val_i,
    output logic [1:0] g_out_o      // {G7,G6}
);

    logic a, b, c, d, e;
    logic w1, w2, w3;
    logic g6, g7;

    assign {a, d, e, c, b} = g_in_i;

    assign w1 = ~(a & b);
    assign w2 = ~(a & c);
    assign w3 = ~(w2 & d);
    assign g6 = ~(w1 & w3);
    assign g7 = (d | e) & w2;

    always_comb begin
        g_out_o = {g7, g6};
        if (force_en_i) begin
            if (force_bit_i) begin
                g_out_o[1] = force_val_i;
            end else begin
                g_out_o[0] = force_val_i;
            end
        end
    end

endmodule

// File: rtl/c17v2_bist_array.sv
// Multi-lane C17V2 array with registered outputs and an LFSR/MISR BIST
// controller; lanes are fed either from data_in or from the pattern LFSR.
module c17v2_bist_array
    import c17_pkg::*;
#(
    parameter int unsigned       LANES     = 4,
    parameter int unsigned       PIPE      = 1,
    parameter int unsigned       LFSR_W    = 24,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(C17_LFSR_TAPS),
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(C17_LFSR_SEED),
    parameter int unsigned       MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(C17_MISR_POLY),
    parameter int unsigned       PATTERNS  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_bist,
    input  logic [5*LANES-1:0]   data_in,
    input  logic                 data_valid,
    output logic [2*LANES-1:0]   data_out,
    output logic                 out_valid,
    input  logic                 start,
    input  logic [MISR_W-1:0]    golden,
    input  logic                 fault_en,
    input  logic [2:0]           fault_lane,
    input  logic                 fault_bit,
    input  logic                 fault_val,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_pass,
    output logic [MISR_W-1:0]    signature
);

    localparam int unsigned DW    = 5 * LANES;
    localparam int unsigned OW    = 2 * LANES;
    localparam int unsigned CNT_W = $clog2(PATTERNS + 1);

    bist_state_e       state_q;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [MISR_W-1:0] misr_q, misr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              start_q, busy_q, done_q;

    logic [DW-1:0]     lane_in;
    logic              in_valid, in_bist;
    logic [OW-1:0]     lane_out;

    logic [OW-1:0]     s1_data_q;
    logic              s1_valid_q, s1_bist_q;
    logic [OW-1:0]     out_data;
    logic              out_vld, out_bist;
    logic              misr_en;

    // Lanes see LFSR patterns only while RUN; any other BIST-mode cycle is idle.
    always_comb begin
        lane_in  = data_in;
        in_valid = data_valid & ~mode_bist;
        in_bist  = 1'b0;
        if (state_q == RUN && mode_bist) begin
            lane_in  = lfsr_q[DW-1:0];
            in_valid = 1'b1;
            in_bist  = 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        c17v2_lane u_lane (
            .g_in_i      (lane_in[5*i +: 5]),
            .force_en_i  (fault_en && (fault_lane == 3'(i))),
            .force_bit_i (fault_bit),
            .force_val_i (fault_val),
            .g_out_o     (lane_out[2*i +: 2])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_bist_q  <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s1_bist_q  <= in_bist;
            if (in_valid) begin
                s1_data_q <= lane_out;
            end
        end
    end

    if (PIPE != 0) begin : g_pipe
        logic [OW-1:0] s2_data_q;
        logic          s2_valid_q, s2_bist_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
                s2_bist_q  <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_bist_q  <= s1_bist_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign out_data = s2_data_q;
        assign out_vld  = s2_valid_q;
        assign out_bist = s2_bist_q;
    end else begin : g_nopipe
        assign out_data = s1_data_q;
        assign out_vld  = s1_valid_q;
        assign out_bist = s1_bist_q;
    end

    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    assign misr_d = {misr_q[MISR_W-2:0], 1'b0}
                  ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                  ^ MISR_W'(misr_fold(16'(out_data), OW, MISR_W));

    // Only BIST-tagged results compact, and only while the run is live, so
    // stale functional data and post-abort leftovers never touch the MISR.
    assign misr_en = out_vld && out_bist && mode_bist
                     && (state_q == RUN || state_q == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start;
            if (misr_en) begin
                misr_q <= misr_d;
            end
            if (busy_q && !mode_bist) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (mode_bist && start) begin
                            state_q <= SEED;
                            busy_q  <= 1'b1;
                        end
                    end
                    SEED: begin
                        lfsr_q  <= LFSR_SEED;
                        misr_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        lfsr_q <= lfsr_d;
                        if (cnt_q == CNT_W'(PATTERNS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= DRAIN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (cnt_q == CNT_W'(PIPE)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DONE: begin
                        if (!mode_bist) begin
                            state_q <= IDLE;
                            done_q  <= 1'b0;
                        end else if (start && !start_q) begin
                            state_q <= SEED;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out  = out_data;
    assign out_valid = out_vld;
    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_pass = done_q && (misr_q == golden);
    assign signature = misr_q;

endmodule
